// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// bus event codes and the default target address.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAITSTOP
  } i2c_state_e;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_START,
    EV_STOP
  } i2c_event_e;

  localparam logic [6:0] I2C_ADDR_DEFAULT = 7'h50;

  // SDA transitions are only meaningful as events while SCL is high.
  function automatic i2c_event_e bus_event(input logic scl_f, input logic sda_q,
                                           input logic sda_f);
    if (scl_f && sda_q && !sda_f) return EV_START;
    if (scl_f && !sda_q && sda_f) return EV_STOP;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/i2c_line_filter_m.sv
// Synchroniser plus glitch filter for one open-drain line; the filtered
// level only moves after FILT_LEN consecutive equal synchronised samples.
module i2c_line_filter_m #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic hsclk,
  input  logic rst,
  input  logic line_in,
  output logic line_f
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_LEN-1:0]    hist_q;

  // Preset high so a reset never looks like a bus transition.
  always_ff @(posedge hsclk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= '1;
      line_f <= 1'b1;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(line_in);
      hist_q <= (hist_q << 1) | FILT_LEN'(sync_q[SYNC_STAGES-1]);
      if (&hist_q)
        line_f <= 1'b1;
      else if (~|hist_q)
        line_f <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_target_m.sv
// I2C target giving an external host byte access to a 2^PTR_W register
// bank through an auto-incrementing pointer. SDA is open-drain, SCL input only.
//
// state        | meaning
// IDLE         | bus free, waiting for START
// ADDR         | shifting in 7-bit address + R/W
// ADDR_ACK     | driving ACK for a matching address
// PTR          | shifting in the register pointer byte
// PTR_ACK      | driving ACK for the pointer byte
// WDATA        | shifting in a write data byte
// WDATA_ACK    | driving ACK for write data, then pointer+1
// RDATA        | driving a read byte MSB first
// RDATA_ACK    | released, sampling the host ACK/NACK
// WAITSTOP     | not addressed or host NACKed; ignore bits
module i2c_target_m
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = I2C_ADDR_DEFAULT,
  parameter int         PTR_W       = 4,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_LEN    = 3
) (
  input  logic             hsclk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_wr,
  output logic             reg_rd,
  input  logic [7:0]       reg_rdata,
  output logic             busy
);

  logic       scl_f, sda_f, scl_q, sda_q;
  logic       scl_rise, scl_fall;
  i2c_event_e ev;
  i2c_state_e state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] rx_byte;
  logic       rw_rd, ack_on, load_pend;

  i2c_line_filter_m #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
    .hsclk(hsclk), .rst(rst), .line_in(scl_in), .line_f(scl_f)
  );

  i2c_line_filter_m #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
    .hsclk(hsclk), .rst(rst), .line_in(sda_in), .line_f(sda_f)
  );

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign ev       = bus_event(scl_f, sda_q, sda_f);
  assign rx_byte  = {shift[6:0], sda_f};

  always_ff @(posedge hsclk or posedge rst) begin
    if (rst) begin
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      rw_rd     <= 1'b0;
      ack_on    <= 1'b0;
      load_pend <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      scl_q  <= scl_f;
      sda_q  <= sda_f;
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      // Post-increment one cycle after the read strobe so the bank sees
      // the captured address while reg_rd is high.
      if (reg_rd)
        reg_addr <= reg_addr + PTR_W'(1);

      if (ev == EV_START) begin
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        ack_on    <= 1'b0;
        load_pend <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
      end else if (ev == EV_STOP) begin
        state     <= ST_IDLE;
        ack_on    <= 1'b0;
        load_pend <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;

          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == ST_ADDR) begin
                  if (shift[6:0] == I2C_ADDR) begin
                    rw_rd <= sda_f;
                    state <= ST_ADDR_ACK;
                  end else begin
                    state <= ST_WAITSTOP;
                  end
                end else if (state == ST_PTR) begin
                  reg_addr <= rx_byte[PTR_W-1:0];
                  state    <= ST_PTR_ACK;
                end else begin
                  reg_wdata <= rx_byte;
                  reg_wr    <= 1'b1;
                  state     <= ST_WDATA_ACK;
                end
              end
            end
          end

          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                if (state == ST_ADDR_ACK) begin
                  if (rw_rd) begin
                    // This fall opens the first read byte.
                    shift  <= reg_rdata;
                    sda_oe <= ~reg_rdata[7];
                    reg_rd <= 1'b1;
                    state  <= ST_RDATA;
                  end else begin
                    state <= ST_PTR;
                  end
                end else if (state == ST_PTR_ACK) begin
                  state <= ST_WDATA;
                end else begin
                  reg_addr <= reg_addr + PTR_W'(1);
                  state    <= ST_WDATA;
                end
              end
            end
          end

          ST_RDATA: begin
            if (scl_fall && load_pend) begin
              load_pend <= 1'b0;
              bit_cnt   <= '0;
              shift     <= reg_rdata;
              sda_oe    <= ~reg_rdata[7];
              reg_rd    <= 1'b1;
            end else if (scl_fall) begin
              sda_oe <= ~shift[6];
              shift  <= {shift[6:0], 1'b0};
            end else if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7)
                state <= ST_RDATA_ACK;
            end
          end

          ST_RDATA_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
            end else if (scl_rise) begin
              if (sda_f) begin
                state <= ST_WAITSTOP;
              end else begin
                state     <= ST_RDATA;
                load_pend <= 1'b1;
              end
            end
          end

          ST_WAITSTOP: sda_oe <= 1'b0;

          default: begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_m.sv
// Directed bench for i2c_target_m: a host model bit-bangs SCL/SDA over a
// wired-AND bus and a small register bank answers reads.
module tb_i2c_target_m;

  localparam int Q = 100;

  logic       hsclk = 1'b0;
  logic       rst;
  logic       scl_in;
  logic       sda_drv;
  logic       sda_in;
  logic       sda_oe;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;

  logic [7:0] bank [16];
  int         chk;
  int         pass;
  int         wr_cnt;
  int         rd_cnt;
  int         oe_cnt;
  logic [3:0] wr_addr_log [16];
  logic [7:0] wr_data_log [16];

  assign sda_in    = sda_drv & ~sda_oe;
  assign reg_rdata = bank[reg_addr];

  i2c_target_m dut (
    .hsclk(hsclk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 hsclk = ~hsclk;

  always @(posedge hsclk) begin
    if (reg_wr) begin
      wr_addr_log[wr_cnt[3:0]] <= reg_addr;
      wr_data_log[wr_cnt[3:0]] <= reg_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (reg_rd) rd_cnt <= rd_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic bus_start();
    sda_drv = 1'b1; #Q;
    scl_in  = 1'b1; #Q;
    sda_drv = 1'b0; #Q;
    scl_in  = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; #Q;
    scl_in  = 1'b1; #Q;
    sda_drv = 1'b1; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = b[i];
      if (i == glitch_bit) begin
        #(Q/2); scl_in = 1'b1; #10; scl_in = 1'b0; #(Q/2 - 10);
      end else begin
        #Q;
      end
      scl_in = 1'b1; #(2*Q);
      scl_in = 1'b0; #Q;
    end
    sda_drv = 1'b1; #Q;
    scl_in  = 1'b1; #Q;
    ack     = sda_in; #Q;
    scl_in  = 1'b0; #Q;
  endtask

  task automatic read_byte(input logic host_ack, output logic [7:0] b);
    sda_drv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl_in = 1'b1;
      #Q; b[i] = sda_in;
      #Q; scl_in = 1'b0;
      #Q;
    end
    sda_drv = host_ack; #Q;
    scl_in  = 1'b1; #(2*Q);
    scl_in  = 1'b0; #Q;
    sda_drv = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; scl_in = 1'b1; sda_drv = 1'b1;
    #50;
    chk++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe); else pass++;
    chk++; if (reg_wr !== 1'b0) $display("FAIL reset_reg_wr: got %b want 0", reg_wr); else pass++;
    chk++; if (reg_rd !== 1'b0) $display("FAIL reset_reg_rd: got %b want 0", reg_rd); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass++;
    chk++; if (reg_addr !== 4'h0) $display("FAIL reset_reg_addr: got %h want 0", reg_addr); else pass++;
    chk++; if (reg_wdata !== 8'h00) $display("FAIL reset_reg_wdata: got %h want 00", reg_wdata); else pass++;
    #50; rst = 1'b0; #Q;
  endtask

  task automatic test_write();
    logic ack;
    int   w0;
    w0 = wr_cnt;
    bus_start();
    write_byte(8'hA0, -1, ack);
    chk++; if (ack !== 1'b0) $display("FAIL wr_addr_ack: got %b want 0", ack); else pass++;
    chk++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", busy); else pass++;
    write_byte(8'h03, -1, ack);
    chk++; if (ack !== 1'b0) $display("FAIL wr_ptr_ack: got %b want 0", ack); else pass++;
    write_byte(8'hA5, -1, ack);
    chk++; if (ack !== 1'b0) $display("FAIL wr_d0_ack: got %b want 0", ack); else pass++;
    write_byte(8'h5A, -1, ack);
    chk++; if (ack !== 1'b0) $display("FAIL wr_d1_ack: got %b want 0", ack); else pass++;
    bus_stop();
    chk++; if (wr_cnt - w0 !== 2) $display("FAIL wr_count: got %0d want 2", wr_cnt - w0); else pass++;
    chk++; if (wr_addr_log[w0[3:0]] !== 4'h3) $display("FAIL wr0_addr: got %h want 3", wr_addr_log[w0[3:0]]); else pass++;
    chk++; if (wr_data_log[w0[3:0]] !== 8'hA5) $display("FAIL wr0_data: got %h want a5", wr_data_log[w0[3:0]]); else pass++;
    chk++; if (wr_addr_log[w0[3:0]+4'd1] !== 4'h4) $display("FAIL wr1_addr: got %h want 4", wr_addr_log[w0[3:0]+4'd1]); else pass++;
    chk++; if (wr_data_log[w0[3:0]+4'd1] !== 8'h5A) $display("FAIL wr1_data: got %h want 5a", wr_data_log[w0[3:0]+4'd1]); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL wr_busy_stop: got %b want 0", busy); else pass++;
    chk++; if (reg_addr !== 4'h5) $display("FAIL wr_ptr_end: got %h want 5", reg_addr); else pass++;
  endtask

  task automatic test_read_wrap();
    logic       ack;
    logic [7:0] b;
    int         r0;
    bus_start();
    write_byte(8'hA0, -1, ack);
    write_byte(8'h0F, -1, ack);
    chk++; if (ack !== 1'b0) $display("FAIL rd_ptr_ack: got %b want 0", ack); else pass++;
    r0 = rd_cnt;
    bus_start();
    write_byte(8'hA1, -1, ack);
    chk++; if (ack !== 1'b0) $display("FAIL rd_addr_ack: got %b want 0", ack); else pass++;
    chk++; if (reg_addr !== 4'h0) $display("FAIL rd_ptr_wrap: got %h want 0", reg_addr); else pass++;
    read_byte(1'b0, b);
    chk++; if (b !== 8'h11) $display("FAIL rd_byte0: got %h want 11", b); else pass++;
    chk++; if (reg_addr !== 4'h1) $display("FAIL rd_ptr1: got %h want 1", reg_addr); else pass++;
    read_byte(1'b0, b);
    chk++; if (b !== 8'h22) $display("FAIL rd_byte1: got %h want 22", b); else pass++;
    chk++; if (reg_addr !== 4'h2) $display("FAIL rd_ptr2: got %h want 2", reg_addr); else pass++;
    read_byte(1'b1, b);
    chk++; if (b !== 8'h33) $display("FAIL rd_byte2: got %h want 33", b); else pass++;
    bus_stop();
    chk++; if (reg_addr !== 4'h2) $display("FAIL rd_ptr_end: got %h want 2", reg_addr); else pass++;
    chk++; if (rd_cnt - r0 !== 3) $display("FAIL rd_strobes: got %0d want 3", rd_cnt - r0); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL rd_busy_stop: got %b want 0", busy); else pass++;
  endtask

  task automatic test_addr_mismatch();
    logic ack;
    int   o0;
    int   w0;
    o0 = oe_cnt;
    w0 = wr_cnt;
    bus_start();
    write_byte(8'hA2, -1, ack);
    chk++; if (ack !== 1'b1) $display("FAIL nm_addr_nack: got %b want 1", ack); else pass++;
    write_byte(8'h77, -1, ack);
    chk++; if (ack !== 1'b1) $display("FAIL nm_data_nack: got %b want 1", ack); else pass++;
    chk++; if (busy !== 1'b1) $display("FAIL nm_busy: got %b want 1", busy); else pass++;
    bus_stop();
    chk++; if (oe_cnt !== o0) $display("FAIL nm_sda_oe: got %0d want %0d", oe_cnt, o0); else pass++;
    chk++; if (wr_cnt !== w0) $display("FAIL nm_no_wr: got %0d want %0d", wr_cnt, w0); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL nm_busy_stop: got %b want 0", busy); else pass++;
  endtask

  task automatic test_scl_glitch();
    logic ack;
    int   w0;
    w0 = wr_cnt;
    bus_start();
    write_byte(8'hA0, -1, ack);
    write_byte(8'h02, -1, ack);
    write_byte(8'h3C, 3, ack);
    chk++; if (ack !== 1'b0) $display("FAIL gl_ack: got %b want 0", ack); else pass++;
    bus_stop();
    chk++; if (wr_cnt - w0 !== 1) $display("FAIL gl_count: got %0d want 1", wr_cnt - w0); else pass++;
    chk++; if (wr_addr_log[w0[3:0]] !== 4'h2) $display("FAIL gl_addr: got %h want 2", wr_addr_log[w0[3:0]]); else pass++;
    chk++; if (wr_data_log[w0[3:0]] !== 8'h3C) $display("FAIL gl_data: got %h want 3c", wr_data_log[w0[3:0]]); else pass++;
    chk++; if (reg_addr !== 4'h3) $display("FAIL gl_ptr: got %h want 3", reg_addr); else pass++;
  endtask

  task automatic test_start_abort();
    logic ack;
    int   w0;
    w0 = wr_cnt;
    bus_start();
    write_byte(8'hA0, -1, ack);
    write_byte(8'h06, -1, ack);
    for (int i = 0; i < 4; i++) begin
      sda_drv = 1'b1; #Q;
      scl_in  = 1'b1; #(2*Q);
      scl_in  = 1'b0; #Q;
    end
    sda_drv = 1'b1; #Q;
    scl_in  = 1'b1; #Q;
    sda_drv = 1'b0; #Q;
    scl_in  = 1'b0; #Q;
    write_byte(8'hA0, -1, ack);
    chk++; if (ack !== 1'b0) $display("FAIL ab_readdr_ack: got %b want 0", ack); else pass++;
    chk++; if (busy !== 1'b1) $display("FAIL ab_busy: got %b want 1", busy); else pass++;
    bus_stop();
    chk++; if (wr_cnt !== w0) $display("FAIL ab_no_wr: got %0d want %0d", wr_cnt, w0); else pass++;
    chk++; if (reg_addr !== 4'h6) $display("FAIL ab_ptr: got %h want 6", reg_addr); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL ab_busy_stop: got %b want 0", busy); else pass++;
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    bus_start();
    write_byte(8'hA1, -1, ack);
    chk++; if (ack !== 1'b0) $display("FAIL rr_addr_ack: got %b want 0", ack); else pass++;
    for (int k = 0; k < 20 && sda_oe !== 1'b1; k++) @(negedge hsclk);
    chk++; if (sda_oe !== 1'b1) $display("FAIL rr_drive: got %b want 1", sda_oe); else pass++;
    #3; rst = 1'b1; #1;
    chk++; if (sda_oe !== 1'b0) $display("FAIL rr_async_oe: got %b want 0", sda_oe); else pass++;
    chk++; if (reg_addr !== 4'h0) $display("FAIL rr_ptr: got %h want 0", reg_addr); else pass++;
    chk++; if (busy !== 1'b0) $display("FAIL rr_busy: got %b want 0", busy); else pass++;
    scl_in = 1'b1; sda_drv = 1'b1;
    #Q; rst = 1'b0; #Q;
    bus_start();
    write_byte(8'hA0, -1, ack);
    chk++; if (ack !== 1'b0) $display("FAIL rr_recover_ack: got %b want 0", ack); else pass++;
    bus_stop();
    chk++; if (busy !== 1'b0) $display("FAIL rr_recover_busy: got %b want 0", busy); else pass++;
  endtask

  initial begin
    chk = 0;
    pass = 0;
    for (int i = 0; i < 16; i++) bank[i] = 8'h00;
    bank[15] = 8'h11;
    bank[0]  = 8'h22;
    bank[1]  = 8'h33;
    test_reset();
    test_write();
    test_read_wrap();
    test_addr_mismatch();
    test_scl_glitch();
    test_start_abort();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule

// File: doc/i2c_target_m.md
Name: i2c_target_m

Overview:
- I2C target (responder) sitting on the board's scl/sda pins.
- Gives an external host or debug controller read/write access to an 8-bit CPLD register bank, such as the map/clock-control and page-register shadows.
- Oversamples SCL/SDA on the high-speed clock and handles a standard 7-bit-address protocol with a register pointer.
- Drives SDA open-drain only; never drives SCL, so there is no clock stretching.

Parameters:
- I2C_ADDR, 7'h50, 7-bit target address this block responds to.
- PTR_W, 4, register pointer width; the bank holds 2^PTR_W registers.
- SYNC_STAGES, 2, synchroniser flops on scl_in/sda_in.
- FILT_LEN, 3, consecutive equal samples needed to accept a line level change.

Ports:
- hsclk  in  1  sole clock; all flops on posedge.
- rst  in  1  asynchronous, active-high reset.
- scl_in  in  1  raw SCL pin level.
- sda_in  in  1  raw SDA pin level.
- sda_oe  out  1  1 pulls SDA low; the top level ties the pad to 1'bz when this is 0.
- reg_addr  out  PTR_W  current register pointer.
- reg_wdata  out  8  write data, valid while reg_wr=1.
- reg_wr  out  1  one-hsclk write strobe.
- reg_rd  out  1  one-hsclk strobe; the bank must present reg_rdata combinationally in that cycle.
- reg_rdata  in  8  read data from the register bank.
- busy  out  1  high from a valid START until STOP or return to IDLE.

Behaviour:
- Interface: one clock (hsclk); reset is asynchronous and active-high (rst).
- Reset values:
  - sda_oe=0, reg_wr=0, reg_rd=0, busy=0, reg_addr=0, reg_wdata=0.
  - State=IDLE; synchronisers and filters preset to 1 (bus released).
- Input conditioning: SYNC_STAGES flops, then a FILT_LEN glitch filter. Edges are derived from the filtered levels scl_f/sda_f.
- Events:
  - START = sda_f falls while scl_f=1.
  - STOP = sda_f rises while scl_f=1.
  - These have priority over every state; a START seen in any state, including mid-byte, aborts and enters ADDR (repeated start).
  - STOP goes to IDLE and releases sda_oe the same cycle.
- Bit timing: receive bits are sampled on the scl_f rising edge, MSB first. sda_oe changes only on the cycle after an scl_f falling edge.
- Bit counter: 3-bit, cleared on START and after each ACK slot.
- States:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits (7 address + R/W).
    - On match: ACK, then PTR if W, or RDATA if R (read begins at the current pointer).
    - On mismatch: go to WAITSTOP with no ACK and sda_oe held 0.
  - ADDR_ACK: sda_oe=1 for exactly one SCL low-high-low period.
  - PTR: first written byte loads reg_addr[PTR_W-1:0]; upper bits are ignored. ACK, then WDATA.
  - WDATA: after 8 bits, reg_wdata=byte and reg_wr=1 for one hsclk on the 8th scl_f rise. ACK, then reg_addr+1, then WDATA.
  - RDATA:
    - On the scl_f fall that enters the byte, pulse reg_rd and capture reg_rdata into the shift register.
    - Drive sda_oe = !bit for 8 bits.
    - Release SDA for the host ACK.
    - Post-increment reg_addr after the capture.
  - RDATA_ACK: sample host bit on scl_f rise. ACK(0) goes to RDATA; NACK(1) goes to WAITSTOP.
  - WAITSTOP: sda_oe=0 and ignores bits until STOP or START.
- Pointer: wraps from 2^PTR_W-1 to 0. It is retained across transactions and reset only by rst.
- busy: 1 in all states except IDLE. It drops the cycle STOP is detected.
- Reset mid-transfer: asynchronous return to reset values with SDA released immediately. No partial write is committed.
- Simultaneous events: if START/STOP coincides with the 8th-bit rise, the event wins and reg_wr is suppressed.

Decomposition:
- Shared package i2c_pkg: state encoding enum, START/STOP event constants, default I2C_ADDR.
- One natural sub-module, i2c_line_filter_m: synchroniser plus glitch filter for a single line, instantiated twice.

Test Plan:
- Write 0x50+W, ptr 0x03, data 0xA5, 0x5A, STOP -> ACK on all 4 bytes; reg_wr pulses with reg_addr=3/wdata=A5 then addr=4/wdata=5A; busy 0 after STOP.
- Write ptr 0x0F, repeated START, 0x50+R, host ACK, ACK, NACK (bank returns 0x11, 0x22, 0x33 at 0x0F, 0x00, 0x01) -> SDA shows 0x11, 0x22, 0x33; reg_addr wraps 0x0F→0x00→0x01→0x02.
- Address 0x51+W, 0x77 -> no ACK on any byte; sda_oe stays 0; no reg_wr; busy 1 until STOP.
- 1-hsclk glitch on SCL during data phase with FILT_LEN=3 -> no extra bit counted; received byte correct.
- START in the middle of the 5th data bit of a write -> no reg_wr; next byte is treated as address and ACKed if 0x50.
- rst asserted during RDATA while sda_oe=1 -> sda_oe=0 asynchronously; reg_addr=0; state IDLE.
